// File: rtl/floating_point_divider.sv
// Sequential IEEE-style floating-point divider: restoring mantissa division,
// one quotient bit per cycle, then a single normalise/round/pack cycle.
module floating_point_divider #(
  parameter int EXPONENT_WIDTH   = 8,
  parameter int MANTISSA_WIDTH   = 23,
  parameter int ROUND_TO_NEAREST = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out,
  output logic                                   underflow_flag,
  output logic                                   overflow_flag,
  output logic                                   invalid_operation_flag,
  output logic                                   divide_by_zero_flag
);

  localparam int E  = EXPONENT_WIDTH;
  localparam int M  = MANTISSA_WIDTH;
  localparam int W  = E + M + 1;
  localparam int XW = E + 2;
  localparam int CW = $clog2(M + 3);

  localparam logic [XW-1:0] BIAS      = XW'((1 << (E - 1)) - 1);
  localparam logic [XW-1:0] EXP_MAX   = XW'((1 << E) - 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(M + 2);
  localparam logic [M-1:0]  QNAN_MAN  = (E == 4 && M == 3) ? {M{1'b1}} : {1'b1, {(M-1){1'b0}}};
  localparam logic [W-1:0]  QNAN      = {1'b1, {E{1'b1}}, QNAN_MAN};

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [M+1:0]    remainder_q, remainder_d;
  logic [M:0]      divisor_q, divisor_d;
  logic [M+2:0]    quotient_q, quotient_d;
  logic [XW-1:0]   exponent_q, exponent_d;
  logic            sign_q, sign_d;
  logic [W-1:0]    out_q, out_d;
  logic [3:0]      flags_q, flags_d;

  logic            aSign, bSign;
  logic [E-1:0]    aExp, bExp;
  logic [M-1:0]    aMan, bMan;
  logic            aZero, bZero, aInf, bInf, aNan, bNan, aSnan, bSnan;
  logic            isSpecial;
  logic [W-1:0]    specialOut;
  logic [3:0]      specialFlags;

  assign aSign = a[W-1];
  assign bSign = b[W-1];
  assign aExp  = a[W-2:M];
  assign bExp  = b[W-2:M];
  assign aMan  = a[M-1:0];
  assign bMan  = b[M-1:0];

  // Subnormals carry no hidden bit here, so any zero exponent is a zero.
  assign aZero = (aExp == '0);
  assign bZero = (bExp == '0);
  assign aInf  = (aExp == {E{1'b1}}) && (aMan == '0);
  assign bInf  = (bExp == {E{1'b1}}) && (bMan == '0);
  assign aNan  = (aExp == {E{1'b1}}) && (aMan != '0);
  assign bNan  = (bExp == {E{1'b1}}) && (bMan != '0);
  assign aSnan = aNan && !aMan[M-1];
  assign bSnan = bNan && !bMan[M-1];

  // Flag vector order: {underflow, overflow, invalid, divide-by-zero}.
  always_comb begin
    isSpecial    = 1'b1;
    specialOut   = '0;
    specialFlags = '0;
    if (aNan || bNan) begin
      specialOut      = QNAN;
      specialFlags[1] = aSnan || bSnan;
    end else if ((aZero && bZero) || (aInf && bInf)) begin
      specialOut      = QNAN;
      specialFlags[1] = 1'b1;
    end else if (aInf) begin
      specialOut = {aSign ^ bSign, {E{1'b1}}, {M{1'b0}}};
    end else if (bZero) begin
      specialOut      = {aSign ^ bSign, {E{1'b1}}, {M{1'b0}}};
      specialFlags[0] = 1'b1;
    end else if (bInf || aZero) begin
      specialOut = {aSign ^ bSign, {(W-1){1'b0}}};
    end else begin
      isSpecial = 1'b0;
    end
  end

  logic            stepGeq;
  logic [M+1:0]    stepDiff, stepSel;

  assign stepGeq  = remainder_q >= {1'b0, divisor_q};
  assign stepDiff = remainder_q - {1'b0, divisor_q};
  assign stepSel  = stepGeq ? stepDiff : remainder_q;

  logic [M:0]      normMan;
  logic            guardBit, stickyBit, roundUp;
  logic [XW-1:0]   normExp, finalExp;
  logic [M+1:0]    rounded;
  logic [M-1:0]    fracOut;
  logic [W-1:0]    roundOut;
  logic [3:0]      roundFlags;

  // Quotient lies in (0.5, 2); a clear integer bit means one extra left shift.
  always_comb begin
    if (quotient_q[M+2]) begin
      normMan   = quotient_q[M+2:2];
      guardBit  = quotient_q[1];
      stickyBit = quotient_q[0] | (|remainder_q);
      normExp   = exponent_q;
    end else begin
      normMan   = quotient_q[M+1:1];
      guardBit  = quotient_q[0];
      stickyBit = |remainder_q;
      normExp   = exponent_q - XW'(1);
    end
    roundUp  = (ROUND_TO_NEAREST != 0) && guardBit && (stickyBit || normMan[0]);
    rounded  = {1'b0, normMan} + {{(M+1){1'b0}}, roundUp};
    finalExp = normExp + {{(XW-1){1'b0}}, rounded[M+1]};
    fracOut  = rounded[M+1] ? rounded[M:1] : rounded[M-1:0];

    roundOut   = {sign_q, finalExp[E-1:0], fracOut};
    roundFlags = '0;
    if (finalExp[XW-1] || (finalExp == '0)) begin
      roundOut   = {sign_q, {(W-1){1'b0}}};
      roundFlags = 4'b1000;
    end else if (finalExp >= EXP_MAX) begin
      roundOut   = {sign_q, {E{1'b1}}, {M{1'b0}}};
      roundFlags = 4'b0100;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign underflow_flag         = flags_q[3];
  assign overflow_flag          = flags_q[2];
  assign invalid_operation_flag = flags_q[1];
  assign divide_by_zero_flag    = flags_q[0];

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    remainder_d = remainder_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    exponent_d  = exponent_q;
    sign_d      = sign_q;
    out_d       = out_q;
    flags_d     = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d = aSign ^ bSign;
          if (isSpecial) begin
            out_d   = specialOut;
            flags_d = specialFlags;
            state_d = DONE;
          end else begin
            count_d     = '0;
            remainder_d = {1'b0, 1'b1, aMan};
            divisor_d   = {1'b1, bMan};
            quotient_d  = '0;
            exponent_d  = {2'b00, aExp} - {2'b00, bExp} + BIAS;
            state_d     = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        remainder_d = stepSel << 1;
        quotient_d  = {quotient_q[M+1:0], stepGeq};
        count_d     = count_q + CW'(1);
        if (count_q == LAST_STEP) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        out_d   = roundOut;
        flags_d = roundFlags;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      remainder_q <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      exponent_q  <= '0;
      sign_q      <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      remainder_q <= remainder_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      exponent_q  <= exponent_d;
      sign_q      <= sign_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_floating_point_divider.sv
// Directed bench for floating_point_divider (FP32): a rounding and a
// truncating instance run in lockstep against a queue of expected results.
module tb_floating_point_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a, b;

  logic        in_ready, out_valid;
  logic [31:0] out;
  logic        underflow_flag, overflow_flag, invalid_operation_flag, divide_by_zero_flag;

  logic        truncInReady, truncOutValid;
  logic [31:0] truncOut;
  logic        truncUf, truncOf, truncInv, truncDz;

  floating_point_divider dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .underflow_flag(underflow_flag), .overflow_flag(overflow_flag),
    .invalid_operation_flag(invalid_operation_flag),
    .divide_by_zero_flag(divide_by_zero_flag)
  );

  floating_point_divider #(.ROUND_TO_NEAREST(0)) dutTrunc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(truncInReady),
    .a(a), .b(b), .out_valid(truncOutValid), .out_ready(out_ready), .out(truncOut),
    .underflow_flag(truncUf), .overflow_flag(truncOf),
    .invalid_operation_flag(truncInv), .divide_by_zero_flag(truncDz)
  );

  always #5 clk = ~clk;

  int cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  typedef struct {
    string       tag;
    logic [31:0] expOut;
    logic [31:0] expTrunc;
    logic [3:0]  expFlags;
    int          expLat;
    int          acceptCycle;
  } item_t;

  item_t scoreboard[$];
  int    checks = 0;
  int    errors = 0;

  localparam logic [3:0] NF  = 4'b0000;
  localparam logic [3:0] UF  = 4'b1000;
  localparam logic [3:0] OF  = 4'b0100;
  localparam logic [3:0] INV = 4'b0010;
  localparam logic [3:0] DZ  = 4'b0001;

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] flagWord();
    return {28'd0, underflow_flag, overflow_flag, invalid_operation_flag, divide_by_zero_flag};
  endfunction

  // Latency is counted in edges after the accept edge; specials land on it.
  task automatic applyStimulus(input string tag, input logic [31:0] opA, input logic [31:0] opB,
                               input logic [31:0] expOut, input logic [31:0] expTrunc,
                               input logic [3:0] expFlags, input int expLat);
    item_t item;
    @(negedge clk);
    compare($sformatf("%s_inReady", tag), 32'(in_ready), 32'd1);
    a = opA;
    b = opB;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    item.tag = tag;
    item.expOut = expOut;
    item.expTrunc = expTrunc;
    item.expFlags = expFlags;
    item.expLat = expLat;
    item.acceptCycle = cycleCount;
    scoreboard.push_back(item);
  endtask

  task automatic checkOutput(input int holdCycles);
    item_t item;
    int guard;
    int latency;
    guard = 0;
    if (scoreboard.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboardEmpty observed=0 expected=1");
      return;
    end
    item = scoreboard.pop_front();
    while (out_valid !== 1'b1 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    latency = cycleCount - item.acceptCycle;
    compare($sformatf("%s_outValid", item.tag), 32'(out_valid), 32'd1);
    compare($sformatf("%s_latency", item.tag), 32'(latency), 32'(item.expLat));
    compare($sformatf("%s_out", item.tag), out, item.expOut);
    compare($sformatf("%s_truncOut", item.tag), truncOut, item.expTrunc);
    compare($sformatf("%s_flags", item.tag), flagWord(), {28'd0, item.expFlags});
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      #1;
      compare($sformatf("%s_holdValid%0d", item.tag, i), 32'(out_valid), 32'd1);
      compare($sformatf("%s_holdOut%0d", item.tag, i), out, item.expOut);
      compare($sformatf("%s_holdFlags%0d", item.tag, i), flagWord(), {28'd0, item.expFlags});
      compare($sformatf("%s_holdInReady%0d", item.tag, i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    compare($sformatf("%s_releasedValid", item.tag), 32'(out_valid), 32'd0);
    compare($sformatf("%s_releasedInReady", item.tag), 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic sawValid;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    compare("reset_inReady", 32'(in_ready), 32'd0);
    compare("reset_outValid", 32'(out_valid), 32'd0);
    compare("reset_out", out, 32'd0);
    compare("reset_flags", flagWord(), 32'd0);
    compare("reset_truncOut", truncOut, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    compare("reset_inReadyAfter", 32'(in_ready), 32'd1);

    applyStimulus("div6by2", 32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, NF, 27);
    checkOutput(0);

    applyStimulus("oneThird", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA, NF, 27);
    checkOutput(5);

    applyStimulus("div7by2", 32'h40E00000, 32'h40000000, 32'h40600000, 32'h40600000, NF, 27);
    a = 32'h3F800000;
    b = 32'h3F800000;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    checkOutput(0);

    applyStimulus("negDiv", 32'hC0C00000, 32'h40000000, 32'hC0400000, 32'hC0400000, NF, 27);
    checkOutput(0);

    applyStimulus("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 32'h7F800000, OF, 27);
    checkOutput(0);

    applyStimulus("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 32'h00000000, UF, 27);
    checkOutput(0);

    applyStimulus("oneByZero", 32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F800000, DZ, 0);
    checkOutput(3);

    applyStimulus("zeroByZero", 32'h00000000, 32'h00000000, 32'hFFC00000, 32'hFFC00000, INV, 0);
    checkOutput(0);

    applyStimulus("sNaN", 32'h7F800001, 32'h3F800000, 32'hFFC00000, 32'hFFC00000, INV, 0);
    checkOutput(0);

    applyStimulus("qNaN", 32'h7FC00000, 32'h3F800000, 32'hFFC00000, 32'hFFC00000, NF, 0);
    checkOutput(0);

    applyStimulus("infByInf", 32'h7F800000, 32'hFF800000, 32'hFFC00000, 32'hFFC00000, INV, 0);
    checkOutput(0);

    applyStimulus("negInfBy2", 32'hFF800000, 32'h40000000, 32'hFF800000, 32'hFF800000, NF, 0);
    checkOutput(0);

    applyStimulus("oneByNegInf", 32'h3F800000, 32'hFF800000, 32'h80000000, 32'h80000000, NF, 0);
    checkOutput(0);

    applyStimulus("negZeroBy2", 32'h80000000, 32'h40000000, 32'h80000000, 32'h80000000, NF, 0);
    checkOutput(0);

    applyStimulus("oneByNegZero", 32'h3F800000, 32'h80000000, 32'hFF800000, 32'hFF800000, DZ, 0);
    checkOutput(0);

    // Abort a division partway through and confirm nothing escapes.
    sawValid = 1'b0;
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    compare("midReset_outValid", 32'(out_valid), 32'd0);
    compare("midReset_inReadyInReset", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    compare("midReset_inReadyAfter", 32'(in_ready), 32'd1);
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1'b1;
    end
    compare("midReset_noResult", 32'(sawValid), 32'd0);

    applyStimulus("afterReset", 32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, NF, 27);
    checkOutput(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
